// File: rtl/alu_serial_frame_rx.sv
// Serial ALU command receiver: 11-bit bytes {START,TYPE,D[7:0],STOP} -> {B,A,OP,ERR} on a valid/ready port.
// Output registered the cycle after the final STOP, held while !OUT_READY; optional ALU_RX_TIMEOUT_EN aborts stalled frames.
module alu_serial_frame_rx #(
  parameter int         DATA_W      = 32,
  parameter logic [7:0] OP_MASK     = 8'h33,
  parameter int         TIMEOUT_CYC = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SIN,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_B,
  output logic [DATA_W-1:0] OUT_A,
  output logic [2:0]        OUT_OP,
  output logic [2:0]        OUT_ERR,
  output logic              FRAME_ERR,
  output logic              OVERRUN
);

  localparam int NB     = DATA_W / 8;
  localparam int NBYTES = 2 * NB;
  localparam int KW     = $clog2(NBYTES + 1);
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES);

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_DATA, S_STOP} state_t;

  state_t              r_state;
  logic                r_type;
  logic [2:0]          r_bit;
  logic [7:0]          r_byte;
  logic [KW-1:0]       r_k;
  logic [3:0]          r_crc;
  logic [2*DATA_W-1:0] r_sr;

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_b;
  logic [DATA_W-1:0]   r_out_a;
  logic [2:0]          r_out_op;
  logic [2:0]          r_out_err;
  logic                r_frame_err;
  logic                r_overrun;

  logic       w_data_ok;
  logic       w_data_err;
  logic       w_crc_err;
  logic       w_op_err;
  logic [2:0] w_err;
  logic       w_crc_en;
  logic       w_crc_in;
  logic       w_timeout;

  // Serial CRC4, poly x^4+x+1, MSB first
  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  assign w_data_ok  = !r_type && (r_k != K_LAST);
  assign w_data_err = !(r_type && (r_k == K_LAST));
  assign w_crc_err  = (r_crc != r_byte[3:0]);
  assign w_op_err   = !OP_MASK[r_byte[6:4]];
  assign w_err      = w_data_err ? 3'b100 :
                      w_crc_err  ? 3'b010 :
                      w_op_err   ? 3'b001 : 3'b000;

  // In the CTL byte, the bit-7 slot carries the constant 1 of the CRC message, then OP; CRC bits are not fed.
  assign w_crc_en = !r_type || (r_bit >= 3'd4);
  assign w_crc_in = (r_type && (r_bit == 3'd7)) ? 1'b1 : SIN;

`ifdef ALU_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_idle_cnt;

  assign w_timeout = (r_state == S_IDLE) && SIN && (r_k != '0) &&
                     (r_idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (RST || (r_state != S_IDLE) || (r_k == '0) || w_timeout)
      r_idle_cnt <= '0;
    else
      r_idle_cnt <= r_idle_cnt + TW'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_type      <= 1'b0;
      r_bit       <= 3'd0;
      r_byte      <= 8'd0;
      r_k         <= '0;
      r_crc       <= 4'd0;
      r_sr        <= '0;
      r_out_valid <= 1'b0;
      r_out_b     <= '0;
      r_out_a     <= '0;
      r_out_op    <= 3'd0;
      r_out_err   <= 3'd0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (OUT_READY)
        r_out_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_k         <= '0;
            r_crc       <= 4'd0;
            r_sr        <= '0;
          end else if (!SIN) begin
            r_state <= S_TYPE;
          end
        end
        S_TYPE: begin
          r_type  <= SIN;
          r_bit   <= 3'd7;
          r_state <= S_DATA;
        end
        S_DATA: begin
          r_byte <= {r_byte[6:0], SIN};
          r_bit  <= r_bit - 3'd1;
          if (w_crc_en)
            r_crc <= crc_step(r_crc, w_crc_in);
          if (r_bit == 3'd0)
            r_state <= S_STOP;
        end
        S_STOP: begin
          r_state <= S_IDLE;
          if (!SIN) begin
            r_frame_err <= 1'b1;
            r_k         <= '0;
            r_crc       <= 4'd0;
            r_sr        <= '0;
          end else if (w_data_ok) begin
            r_sr <= {r_sr[2*DATA_W-9:0], r_byte};
            r_k  <= r_k + KW'(1);
          end else begin
            r_k   <= '0;
            r_crc <= 4'd0;
            r_sr  <= '0;
            // Output slot is free if empty or being drained this very cycle.
            if (!r_out_valid || OUT_READY) begin
              r_out_valid <= 1'b1;
              r_out_b     <= r_sr[2*DATA_W-1:DATA_W];
              r_out_a     <= r_sr[DATA_W-1:0];
              r_out_op    <= w_data_err ? 3'd0 : r_byte[6:4];
              r_out_err   <= w_err;
            end else begin
              r_overrun <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign OUT_VALID = r_out_valid;
  assign OUT_B     = r_out_b;
  assign OUT_A     = r_out_a;
  assign OUT_OP    = r_out_op;
  assign OUT_ERR   = r_out_err;
  assign FRAME_ERR = r_frame_err;
  assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_alu_serial_frame_rx.sv
// Directed bench for alu_serial_frame_rx: a 32-bit default instance and a 16-bit instance (OP_MASK=8'h01, TIMEOUT_CYC=8).
// Build with ALU_RX_TIMEOUT_EN defined to exercise the inter-byte timeout on the 16-bit instance.
module tb_alu_serial_frame_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sin1, ready1, valid1, ferr1, ovr1;
  logic [31:0] b1, a1;
  logic [2:0]  op1, err1;
  logic        sin2, ready2, valid2, ferr2, ovr2;
  logic [15:0] b2, a2;
  logic [2:0]  op2, err2;

  logic sel;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_serial_frame_rx u_dut32 (
    .CLK(clk), .RST(rst), .SIN(sin1), .OUT_VALID(valid1), .OUT_READY(ready1),
    .OUT_B(b1), .OUT_A(a1), .OUT_OP(op1), .OUT_ERR(err1), .FRAME_ERR(ferr1), .OVERRUN(ovr1)
  );

  alu_serial_frame_rx #(.DATA_W(16), .OP_MASK(8'h01), .TIMEOUT_CYC(8)) u_dut16 (
    .CLK(clk), .RST(rst), .SIN(sin2), .OUT_VALID(valid2), .OUT_READY(ready2),
    .OUT_B(b2), .OUT_A(a2), .OUT_OP(op2), .OUT_ERR(err2), .FRAME_ERR(ferr2), .OVERRUN(ovr2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: long-hand serial division over {B, A, 1'b1, OP}.
  function automatic logic [3:0] crc_bit(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] crc4(input logic [63:0] b, input logic [63:0] a,
                                      input int w, input logic [2:0] op);
    logic [3:0] c;
    c = 4'h0;
    for (int i = w - 1; i >= 0; i--) c = crc_bit(c, b[i]);
    for (int i = w - 1; i >= 0; i--) c = crc_bit(c, a[i]);
    c = crc_bit(c, 1'b1);
    for (int i = 2; i >= 0; i--) c = crc_bit(c, op[i]);
    return c;
  endfunction

  // Present a bit, let the DUT sample it, then settle 1ns past the edge.
  task automatic drive_bit(input logic v);
    if (sel) sin2 = v;
    else     sin1 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_byte(input logic typ, input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    drive_bit(typ);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic send_frame(input logic [63:0] b, input logic [63:0] a, input int w,
                            input logic [2:0] op, input logic [3:0] crc);
    for (int i = w / 8 - 1; i >= 0; i--) send_byte(1'b0, b[i*8 +: 8], 1'b1);
    for (int i = w / 8 - 1; i >= 0; i--) send_byte(1'b0, a[i*8 +: 8], 1'b1);
    send_byte(1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  initial begin
    rst = 1'b1; sin1 = 1'b1; sin2 = 1'b1; ready1 = 1'b1; ready2 = 1'b1; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid1, 0);
    check("rst_b", b1, 0);
    check("rst_a", a1, 0);
    check("rst_op_err", {op1, err1}, 0);
    check("rst_pulses", {ferr1, ovr1, valid2}, 0);
    rst = 1'b0;
    idle_cycles(3);

    // Basic decode; CRC of {2,1,1,100} is 4'hC by hand.
    send_frame(64'h2, 64'h1, 32, 3'b100, 4'hC);
    check("t1_valid", valid1, 1);
    check("t1_b", b1, 32'h2);
    check("t1_a", a1, 32'h1);
    check("t1_op", op1, 3'd4);
    check("t1_err", err1, 3'b000);
    idle_cycles(1);
    check("t1_valid_drop", valid1, 0);

    // CTL in place of the 4th B byte.
    for (int i = 0; i < 3; i++) send_byte(1'b0, 8'h00, 1'b1);
    send_byte(1'b1, 8'h02, 1'b1);
    check("t2_valid", valid1, 1);
    check("t2_err", err1, 3'b100);
    check("t2_op", op1, 3'd0);
    send_frame(64'hDEADBEEF, 64'h12345678, 32, 3'd5, crc4(64'hDEADBEEF, 64'h12345678, 32, 3'd5));
    check("t2_next_b", b1, 32'hDEADBEEF);
    check("t2_next_a", a1, 32'h12345678);
    check("t2_next_op_err", {op1, err1}, {3'd5, 3'b000});
    // DATA byte where the CTL byte belongs.
    for (int i = 0; i < 9; i++) send_byte(1'b0, 8'h11, 1'b1);
    check("t2_extra_data_err", {valid1, err1}, {1'b1, 3'b100});

    // CRC error, then illegal opcode with good CRC.
    send_frame(64'hA5A5A5A5, 64'h0F0F0F0F, 32, 3'd1,
               crc4(64'hA5A5A5A5, 64'h0F0F0F0F, 32, 3'd1) ^ 4'h1);
    check("t3_crc_err", {valid1, err1}, {1'b1, 3'b010});
    send_frame(64'h2, 64'h1, 32, 3'b111, crc4(64'h2, 64'h1, 32, 3'b111));
    check("t3_op_err", {valid1, err1}, {1'b1, 3'b001});
    check("t3_op", op1, 3'd7);

    // Backpressure and overrun.
    idle_cycles(1);
    ready1 = 1'b0;
    send_frame(64'h2, 64'h1, 32, 3'b100, 4'hC);
    check("t4_f1_valid", valid1, 1);
    send_frame(64'h55, 64'h10, 32, 3'd0, crc4(64'h55, 64'h10, 32, 3'd0));
    check("t4_overrun", ovr1, 1);
    check("t4_held", {valid1, b1, a1, op1, err1}, {1'b1, 32'h2, 32'h1, 3'd4, 3'b000});
    idle_cycles(1);
    check("t4_overrun_pulse", ovr1, 0);
    check("t4_still_held", {valid1, b1, a1}, {1'b1, 32'h2, 32'h1});
    ready1 = 1'b1;
    idle_cycles(1);
    check("t4_drained", valid1, 0);
    idle_cycles(3);
    check("t4_no_frame2", valid1, 0);

    // Bad STOP on byte 3.
    send_byte(1'b0, 8'h00, 1'b1);
    send_byte(1'b0, 8'h00, 1'b1);
    send_byte(1'b0, 8'h00, 1'b0);
    check("t5_frame_err", {ferr1, valid1}, {1'b1, 1'b0});
    drive_bit(1'b1);
    check("t5_frame_err_pulse", {ferr1, valid1}, 0);
    // Pending output plus a partial frame, then RST.
    ready1 = 1'b0;
    send_frame(64'h2, 64'h1, 32, 3'b100, 4'hC);
    check("t5_pending", valid1, 1);
    for (int i = 0; i < 4; i++) send_byte(1'b0, 8'hFF, 1'b1);
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
    rst = 1'b1;
    drive_bit(1'b1);
    check("t5_rst_outputs", {valid1, b1, a1, op1, err1, ferr1, ovr1}, 0);
    rst = 1'b0;
    ready1 = 1'b1;
    send_frame(64'h01020304, 64'h05060708, 32, 3'd0, crc4(64'h01020304, 64'h05060708, 32, 3'd0));
    check("t5_clean_ba", {valid1, b1, a1}, {1'b1, 32'h01020304, 32'h05060708});
    check("t5_clean_err", err1, 3'b000);

    // 16-bit instance.
    sel = 1'b1;
    send_frame(64'hFFFF, 64'h0001, 16, 3'd0, crc4(64'hFFFF, 64'h0001, 16, 3'd0));
    check("t6_valid_err", {valid2, err2, op2}, {1'b1, 3'b000, 3'd0});
    check("t6_ba", {b2, a2}, {16'hFFFF, 16'h0001});
    send_byte(1'b0, 8'h12, 1'b1);
    send_byte(1'b0, 8'h34, 1'b1);
`ifdef ALU_RX_TIMEOUT_EN
    idle_cycles(7);
    check("t6_no_timeout_yet", ferr2, 0);
    idle_cycles(1);
    check("t6_timeout", {ferr2, valid2}, {1'b1, 1'b0});
    idle_cycles(1);
    check("t6_timeout_pulse", {ferr2, valid2}, 0);
    send_frame(64'h1234, 64'h00FF, 16, 3'd0, crc4(64'h1234, 64'h00FF, 16, 3'd0));
    check("t6_after_timeout", {valid2, b2, a2, err2}, {1'b1, 16'h1234, 16'h00FF, 3'b000});
`else
    idle_cycles(20);
    check("t6_long_gap", {ferr2, valid2}, 0);
    send_byte(1'b0, 8'h00, 1'b1);
    send_byte(1'b0, 8'hFF, 1'b1);
    send_byte(1'b1, {1'b0, 3'd0, crc4(64'h1234, 64'h00FF, 16, 3'd0)}, 1'b1);
    check("t6_after_gap", {valid2, b2, a2, err2}, {1'b1, 16'h1234, 16'h00FF, 3'b000});
`endif
    sel = 1'b0;
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
